// File: rtl/decade_6.sv
// decade_6: six-position counter (zero plus five one-hot codes) with illegal-code recovery.
// Define DECADE6_CARRY_EN to add the o_carry wrap pulse for cascading a following counter.
module decade_6 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [4:0] o_output,
`ifdef DECADE6_CARRY_EN
  output logic       o_carry,
`endif
  output logic       o_error
);

  typedef enum logic [4:0] {
    P0 = 5'b00000,
    P1 = 5'b00001,
    P2 = 5'b00010,
    P3 = 5'b00100,
    P4 = 5'b01000,
    P5 = 5'b10000
  } pos_t;

  // Held as plain bits rather than pos_t so an upset can leave a multi-bit code behind.
  logic [4:0] pos_q;
  logic [4:0] pos_d;
  logic       illegal;
  logic       error_q;
  logic       error_d;
`ifdef DECADE6_CARRY_EN
  logic       carry_q;
  logic       carry_d;
`endif

  // Two or more bits set: clearing the lowest set bit still leaves something.
  assign illegal = |(pos_q & (pos_q - 5'd1));

  always_comb begin
    pos_d   = pos_q;
    error_d = 1'b0;
`ifdef DECADE6_CARRY_EN
    carry_d = 1'b0;
`endif
    if (illegal) begin
      pos_d   = P0;
      error_d = 1'b1;
    end else if (i_clear) begin
      pos_d = P0;
    end else if (i_advance) begin
      case (pos_q)
        P0:      pos_d = P1;
        P1:      pos_d = P2;
        P2:      pos_d = P3;
        P3:      pos_d = P4;
        P4:      pos_d = P5;
        P5: begin
          pos_d = P0;
`ifdef DECADE6_CARRY_EN
          carry_d = 1'b1;
`endif
        end
        default: pos_d = P0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q   <= P0;
      error_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      error_q <= error_d;
    end
  end

`ifdef DECADE6_CARRY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign o_carry = carry_q;
`endif

  assign o_output = pos_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_decade_6.sv
// tb_decade_6: randomized scoreboard bench for decade_6 against a position-index reference model.
// Honours DECADE6_CARRY_EN the same way the design does.
module tb_decade_6;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_clear;
  logic       i_advance;
  logic [4:0] o_output;
  logic       o_error;
`ifdef DECADE6_CARRY_EN
  logic       o_carry;
`endif

  decade_6 dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (i_clear),
    .i_advance (i_advance),
    .o_output  (o_output),
`ifdef DECADE6_CARRY_EN
    .o_carry   (o_carry),
`endif
    .o_error   (o_error)
  );

  typedef struct {
    logic [4:0] pos;
    logic       carry;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   model_idx   = 0;
  bit   model_corrupt = 1'b0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Position index 0..5 maps to the zero code or a single set bit.
  function automatic logic [4:0] code_of(input int idx);
    logic [4:0] one;
    one = 5'd1;
    return (idx == 0) ? 5'd0 : (one << (idx - 1));
  endfunction

  task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  // Called at a falling edge: drive inputs, advance the model one edge, queue the expected outputs.
  task automatic applyStimulus(input logic clr, input logic adv);
    exp_t e;
    i_clear   = clr;
    i_advance = adv;
    e.carry = 1'b0;
    e.err   = 1'b0;
    if (model_corrupt) begin
      model_idx     = 0;
      e.err         = 1'b1;
      model_corrupt = 1'b0;
    end else if (clr) begin
      model_idx = 0;
    end else if (adv) begin
      if (model_idx == 5) e.carry = 1'b1;
      model_idx = (model_idx + 1) % 6;
    end
    e.pos = code_of(model_idx);
    exp_q.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic checkResetNow(input string name);
    checkOutput({name, "_pos"}, o_output, 5'd0);
    checkOutput({name, "_err"}, {4'd0, o_error}, 5'd0);
`ifdef DECADE6_CARRY_EN
    checkOutput({name, "_carry"}, {4'd0, o_carry}, 5'd0);
`endif
  endtask

  task automatic injectIllegal(input logic [4:0] code);
    force dut.pos_q = code;
    #1;
    release dut.pos_q;
    model_corrupt = 1'b1;
  endtask

  // Monitor: every edge that has a queued expectation is compared just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("position", o_output, e.pos);
        checkOutput("error", {4'd0, o_error}, {4'd0, e.err});
`ifdef DECADE6_CARRY_EN
        checkOutput("carry", {4'd0, o_carry}, {4'd0, e.carry});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int b;
    i_rst_n   = 1'b0;
    i_clear   = 1'b0;
    i_advance = 1'b0;
    repeat (3) @(negedge i_clk);
    checkResetNow("reset");
    i_rst_n = 1'b1;
    model_idx = 0;

    repeat (6) applyStimulus(1'b0, 1'b1);

    repeat (10) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end

    repeat (5) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    repeat (4) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);

    // Asynchronous reset between edges at P2.
    repeat (2) applyStimulus(1'b0, 1'b1);
    #2 i_rst_n = 1'b0;
    #1 checkResetNow("async_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_idx = 0;

    // Reset while the wrap carry is showing must drop it.
    repeat (6) applyStimulus(1'b0, 1'b1);
    #2 i_rst_n = 1'b0;
    #1 checkResetNow("reset_drops_carry");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_idx = 0;

    injectIllegal(5'b00110);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 25) begin
        a = $urandom_range(0, 4);
        b = (a + $urandom_range(1, 4)) % 5;
        injectIllegal(5'((1 << a) | (1 << b)));
      end
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    i_clear   = 1'b0;
    i_advance = 1'b0;
    @(negedge i_clk);
    checkOutput("queue_drained", 5'(exp_q.size()), 5'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
